// File: rtl/mano_ir_reg.sv
// Mano basic computer instruction register: captures the fetched word at T1
// and decodes the indirect bit, one-hot opcode, address field and instruction class.
module mano_ir_reg #(
  parameter int unsigned WIDTH  = 16,
  parameter logic [2:0]  LOAD_T = 3'b001
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_IR,
  input  logic [2:0]       t,
  output logic [WIDTH-1:0] Q_IR,
  output logic             I_BIT,
  output logic [7:0]       D,
  output logic [11:0]      ADDR,
  output logic             REG_REF,
  output logic             IO_REF,
  output logic             MEM_REF
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      Q_IR <= '0;
    else if (t == LOAD_T)
      Q_IR <= IN_IR;
  end

  // Field positions are fixed by the 16-bit Mano instruction format.
  always_comb begin
    D              = '0;
    D[Q_IR[14:12]] = 1'b1;
  end

  assign I_BIT   = Q_IR[15];
  assign ADDR    = Q_IR[11:0];
  assign REG_REF = D[7] & ~I_BIT;
  assign IO_REF  = D[7] &  I_BIT;
  assign MEM_REF = ~D[7];

endmodule

// File: tb/tb_mano_ir_reg.sv
// Self-checking bench for mano_ir_reg: directed scenarios plus randomized
// load/hold/reset traffic checked against an arithmetic instruction-format model.
module tb_mano_ir_reg;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] IN_IR = '0;
  logic [2:0]  t = '0;
  logic [15:0] Q_IR;
  logic        I_BIT;
  logic [7:0]  D;
  logic [11:0] ADDR;
  logic        REG_REF, IO_REF, MEM_REF;

  mano_ir_reg #(.WIDTH(16), .LOAD_T(3'b001)) dut (
    .CLK(CLK), .RST(RST), .IN_IR(IN_IR), .t(t), .Q_IR(Q_IR), .I_BIT(I_BIT),
    .D(D), .ADDR(ADDR), .REG_REF(REG_REF), .IO_REF(IO_REF), .MEM_REF(MEM_REF)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [15:0] model_q = '0;
  logic [39:0] obs;

  assign obs = {Q_IR, I_BIT, D, ADDR, REG_REF, IO_REF, MEM_REF};

  // Expected outputs from the instruction word, computed with plain arithmetic.
  function automatic logic [39:0] exp_outs(input logic [15:0] q);
    int unsigned op, ind, addr;
    logic [7:0] d;
    op   = (int'(q) / 4096) % 8;
    ind  = int'(q) / 32768;
    addr = int'(q) % 4096;
    d    = 8'(1 << op);
    return {q, 1'(ind), d, 12'(addr), (op == 7 && ind == 0), (op == 7 && ind == 1), (op != 7)};
  endfunction

  task automatic clk_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; t = 3'b000; IN_IR = 16'h5123;
    model_q = '0;
    for (int i = 0; i < 2; i++) begin
      clk_edge();
      checks++;
      if (obs !== exp_outs(model_q) || D !== 8'h01 || MEM_REF !== 1'b1) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs, exp_outs(model_q));
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_load_zero();
    t = 3'b001; IN_IR = 16'h0000;
    clk_edge();
    model_q = 16'h0000;
    checks++;
    if (obs !== exp_outs(model_q)) begin
      errors++;
      $display("FAIL load_zero: got %h want %h", obs, exp_outs(model_q));
    end
  endtask

  task automatic test_load_basic();
    t = 3'b001; IN_IR = 16'h5123;
    clk_edge();
    model_q = 16'h5123;
    checks++;
    if (obs !== exp_outs(model_q) || Q_IR !== 16'h5123 || D !== 8'h20 || ADDR !== 12'h123) begin
      errors++;
      $display("FAIL load_basic: got %h want %h", obs, exp_outs(model_q));
    end
  endtask

  task automatic test_hold();
    for (int v = 0; v < 8; v++) begin
      if (v == 1) continue;
      t = 3'(v); IN_IR = 16'hFFFF;
      clk_edge();
      checks++;
      if (obs !== exp_outs(model_q) || Q_IR !== 16'h5123) begin
        errors++;
        $display("FAIL hold t=%0d: got %h want %h", v, obs, exp_outs(model_q));
      end
    end
  endtask

  task automatic test_classes();
    logic [15:0] words [3] = '{16'h7800, 16'hF400, 16'h8ABC};
    for (int i = 0; i < 3; i++) begin
      t = 3'b001; IN_IR = words[i];
      clk_edge();
      model_q = words[i];
      checks++;
      if (obs !== exp_outs(model_q)) begin
        errors++;
        $display("FAIL class %h: got %h want %h", words[i], obs, exp_outs(model_q));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom);
      t = 3'b001; IN_IR = v;
      clk_edge();
      model_q = v;
      // Input changes after the loading edge must not reach the outputs.
      IN_IR = ~v; t = 3'b000;
      #3;
      checks++;
      if (obs !== exp_outs(model_q)) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, exp_outs(model_q));
      end
    end
  endtask

  task automatic test_async_reset();
    t = 3'b001; IN_IR = 16'h1234;
    clk_edge();
    model_q = 16'h1234;
    RST = 1'b1;
    #1;
    model_q = '0;
    checks++;
    if (obs !== exp_outs(model_q)) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h want %h", obs, exp_outs(model_q));
    end
    for (int i = 0; i < 2; i++) begin
      clk_edge();
      checks++;
      if (obs !== exp_outs(model_q)) begin
        errors++;
        $display("FAIL async_reset_held[%0d]: got %h want %h", i, obs, exp_outs(model_q));
      end
    end
    RST = 1'b0;
    IN_IR = 16'hC3A5;
    clk_edge();
    model_q = 16'hC3A5;
    checks++;
    if (obs !== exp_outs(model_q)) begin
      errors++;
      $display("FAIL reset_release_load: got %h want %h", obs, exp_outs(model_q));
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [2:0]  tv;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0) begin
        RST = 1'b1;
        #1;
        model_q = '0;
        checks++;
        if (obs !== exp_outs(model_q)) begin
          errors++;
          $display("FAIL random_rst[%0d]: got %h want %h", i, obs, exp_outs(model_q));
        end
        t = 3'($urandom); IN_IR = 16'($urandom);
        clk_edge();
        RST = 1'b0;
      end else begin
        v  = 16'($urandom);
        tv = ($urandom_range(1) == 1) ? 3'b001 : 3'($urandom);
        t = tv; IN_IR = v;
        clk_edge();
        if (tv == 3'b001) model_q = v;
        IN_IR = 16'($urandom);
        #1;
      end
      checks++;
      if (obs !== exp_outs(model_q)) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_outs(model_q));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_zero();
    test_load_basic();
    test_hold();
    test_classes();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
